shk_to_bram: RTL and testbench
==============================

// Module: shk_to_bram
// PURPOSE
// - Shake-bus slave that accepts one write burst from a shake master and stores it in BRAM.
// - Receive-side counterpart of the BRAM-to-shake DDR write path.
// - Sits between a shake master (DDR read engine or loopback) and a simple dual-port BRAM write port.
// - Raises m_info_rd_last when a full burst has been written, so the downstream reader can start.
// PARAMETERS
// - WD_SHK_DATA   64  shake data width; BRAM data width is equal to this
// - WD_SHK_ADDR   32  shake address width
// - WD_BRAM_ADDR  8   BRAM address width
// - NB_BURST      256 beats per burst; 2..2**WD_BRAM_ADDR
// - NB_MDATA_DELY 1   cycles from the s_shk_src_ssync pulse until s_shk_src_mdata is valid; 1..15
// - WD_ERR_INFO   4   error vector width; >=3
// PORTS
// - i_sys_clk        in  1             system clock, all logic on rising edge
// - i_sys_reset      in  1             asynchronous, active-high reset
// - s_shk_src_valid  in  1             request pulse from master
// - s_shk_src_msync  in  1             1 = write request, 0 = read request (unsupported)
// - s_shk_src_mdata  in  WD_SHK_DATA   beat data from master
// - s_shk_src_maddr  in  WD_SHK_ADDR   burst base byte address, sampled with valid
// - s_shk_src_ready  out 1             1-cycle pulse, burst finished
// - s_shk_src_ssync  out 1             1-cycle pulse, requests the next beat
// - s_shk_src_sdata  out WD_SHK_DATA   status data (see CONFIGURATION)
// - s_shk_src_saddr  out WD_SHK_ADDR   byte address of the current beat
// - m_bram_dst_clk   out 1             = i_sys_clk
// - m_bram_dst_addr  out WD_BRAM_ADDR  write address = beat index
// - m_bram_dst_din   out WD_SHK_DATA   write data
// - m_bram_dst_dout  in  WD_SHK_DATA   unused
// - m_bram_dst_en    out 1             = m_bram_dst_we
// - m_bram_dst_we    out 1             write strobe
// - m_bram_dst_rst   out 1             constant 0
// - m_info_rd_last   out 1             1-cycle pulse, asserted in the same cycle as s_shk_src_ready
// - m_err_bram_info1 out WD_ERR_INFO   sticky error flags
// BEHAVIOUR
// - Reset: all registered outputs 0, state IDLE, beat_cnt 0, delay_cnt 0. Takes effect immediately and aborts any burst; no ready pulse is issued.
// - States: IDLE, REQ, WAIT, WR, DONE.
// - IDLE: on valid with msync=1, latch maddr into base and go to REQ.
// - IDLE: on valid with msync=0, set err[0] and go to DONE; no BRAM writes.
// - REQ: ssync=1 for 1 cycle, then WAIT.
// - WAIT: delay_cnt counts up; when delay_cnt reaches NB_MDATA_DELY-1, go to WR. WAIT lasts NB_MDATA_DELY cycles.
// - WR: capture mdata (registered) and drive we=en=1 for 1 cycle with addr=beat_cnt, din=mdata.
// - WR: if beat_cnt==NB_BURST-1, clear beat_cnt and go to DONE; otherwise beat_cnt+1 and go to REQ.
// - DONE: ready=1 and m_info_rd_last=1 for 1 cycle, then IDLE.
// - Beat period is 2+NB_MDATA_DELY cycles.
// - saddr = base + beat_cnt*(WD_SHK_DATA/8), computed modulo 2**WD_SHK_ADDR, registered. It is 0 in IDLE.
// - beat_cnt is WD_BRAM_ADDR+1 bits wide, so NB_BURST=2**WD_BRAM_ADDR ends at address all-ones with no overflow.
// - valid outside IDLE is ignored, and err[1] is set. The burst in progress is unaffected.
// - valid in DONE is also ignored; requests are accepted only in IDLE.
// - err[2] is set when maddr is not aligned to WD_SHK_DATA/8 bytes; the burst still runs.
// - Upper err bits are 0. Flags clear only on reset.
// CONFIGURATION
// - Macro SHK_TO_BRAM_ECHO_EN.
// - Defined: s_shk_src_sdata holds the last data word written to BRAM, updated in the cycle after each WR, for loopback checks.
// - Undefined: s_shk_src_sdata is constant 0.
// TESTING
// - NB_BURST=4, NB_MDATA_DELY=1. Valid pulse with msync=1, maddr=0x0200_0000; master drives mdata=0xA0+k one cycle after the k-th ssync.
//   Required: BRAM writes addr0..3 = A0..A3; ssync every 3 cycles; saddr 0x0200_0000/08/10/18; one ready and one last pulse.
// - Valid with msync=0, maddr=0x0400_0000.
//   Required: no we; ready 2 cycles after valid; err=4'b0001.
// - Second valid during beat 1 of a burst.
//   Required: ignored; the burst writes all 4 beats unchanged; err[1]=1.
// - Assert reset after the 2nd write.
//   Required: all outputs 0 at once; no ready. After release, a new valid starts at BRAM addr 0.
// - NB_BURST=256, NB_MDATA_DELY=3.
//   Required: last write at addr 255; beat period 5 cycles; ready after beat 255; beat_cnt back to 0. Misaligned maddr 0x...04 sets err[2].
// - Build with SHK_TO_BRAM_ECHO_EN defined.
//   Required: sdata=0xA3 after test 1. Without the macro, sdata stays 0 throughout.

Source files
------------

// File: rtl/shk_to_bram_if.sv
// Shake-bus bundle between a burst master and the shk_to_bram slave.
// The master raises valid with msync/maddr; the slave paces beats with ssync and ends with ready.
interface shk_to_bram_if #(
   parameter int WD_SHK_DATA = 64,
   parameter int WD_SHK_ADDR = 32
);
   logic                   valid;
   logic                   msync;
   logic [WD_SHK_DATA-1:0] mdata;
   logic [WD_SHK_ADDR-1:0] maddr;
   logic                   ready;
   logic                   ssync;
   logic [WD_SHK_DATA-1:0] sdata;
   logic [WD_SHK_ADDR-1:0] saddr;

   modport master (
      output valid, msync, mdata, maddr,
      input  ready, ssync, sdata, saddr
   );

   modport slave (
      input  valid, msync, mdata, maddr,
      output ready, ssync, sdata, saddr
   );
endinterface

// File: rtl/shk_to_bram.sv
// Shake-bus slave: accepts one write burst, paces beats with ssync and stores them in a BRAM write port.
// Optional macro SHK_TO_BRAM_ECHO_EN: sdata echoes the last word written to BRAM (otherwise sdata is 0).
module shk_to_bram #(
   parameter int WD_SHK_DATA   = 64,
   parameter int WD_SHK_ADDR   = 32,
   parameter int WD_BRAM_ADDR  = 8,
   parameter int NB_BURST      = 256,
   parameter int NB_MDATA_DELY = 1,
   parameter int WD_ERR_INFO   = 4
) (
   input  logic                    i_sys_clk,
   input  logic                    i_sys_reset,
   shk_to_bram_if.slave            s_shk_src,
   output logic                    m_bram_dst_clk,
   output logic [WD_BRAM_ADDR-1:0] m_bram_dst_addr,
   output logic [WD_SHK_DATA-1:0]  m_bram_dst_din,
   input  logic [WD_SHK_DATA-1:0]  m_bram_dst_dout,
   output logic                    m_bram_dst_en,
   output logic                    m_bram_dst_we,
   output logic                    m_bram_dst_rst,
   output logic                    m_info_rd_last,
   output logic [WD_ERR_INFO-1:0]  m_err_bram_info1
);

   localparam int                      WD_BEAT     = WD_BRAM_ADDR + 1;
   localparam logic [WD_BEAT-1:0]      BEAT_LAST   = WD_BEAT'(NB_BURST - 1);
   localparam logic [3:0]              DLY_LAST    = 4'(NB_MDATA_DELY - 1);
   localparam logic [WD_SHK_ADDR-1:0]  BEAT_BYTES  = WD_SHK_ADDR'(WD_SHK_DATA / 8);
   localparam logic [WD_SHK_ADDR-1:0]  ALIGN_MASK  = WD_SHK_ADDR'(WD_SHK_DATA / 8 - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_WR,
      ST_DONE
   } state_t;

   state_t                  state_q,     state_d;
   logic [WD_SHK_ADDR-1:0]  base_q,      base_d;
   logic [WD_BEAT-1:0]      beat_cnt_q,  beat_cnt_d;
   logic [3:0]              delay_cnt_q, delay_cnt_d;
   logic                    ssync_q,     ssync_d;
   logic                    ready_q,     ready_d;
   logic                    we_q,        we_d;
   logic [WD_BRAM_ADDR-1:0] addr_q,      addr_d;
   logic [WD_SHK_DATA-1:0]  din_q,       din_d;
   logic [WD_SHK_ADDR-1:0]  saddr_q,     saddr_d;
   logic [WD_SHK_DATA-1:0]  sdata_q,     sdata_d;
   logic [WD_ERR_INFO-1:0]  err_q,       err_d;

   // The read-data port exists only for pin compatibility with the BRAM.
   logic unused_dout;
   assign unused_dout = ^m_bram_dst_dout;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      state_d     = state_q;
      base_d      = base_q;
      beat_cnt_d  = beat_cnt_q;
      delay_cnt_d = delay_cnt_q;
      ssync_d     = 1'b0;
      ready_d     = 1'b0;
      we_d        = 1'b0;
      addr_d      = addr_q;
      din_d       = din_q;
      err_d       = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (s_shk_src.valid) begin
               if (s_shk_src.msync) begin
                  base_d  = s_shk_src.maddr;
                  state_d = ST_REQ;
                  if ((s_shk_src.maddr & ALIGN_MASK) != '0) err_d[2] = 1'b1;
               end else begin
                  err_d[0] = 1'b1;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_REQ: begin
            ssync_d = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (delay_cnt_q == DLY_LAST) begin
               delay_cnt_d = '0;
               state_d     = ST_WR;
            end else begin
               delay_cnt_d = delay_cnt_q + 4'd1;
            end
         end
         ST_WR: begin
            we_d   = 1'b1;
            addr_d = beat_cnt_q[WD_BRAM_ADDR-1:0];
            din_d  = s_shk_src.mdata;
            if (beat_cnt_q == BEAT_LAST) begin
               beat_cnt_d = '0;
               state_d    = ST_DONE;
            end else begin
               beat_cnt_d = beat_cnt_q + WD_BEAT'(1);
               state_d    = ST_REQ;
            end
         end
         ST_DONE: begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Requests only land in IDLE; anything else is flagged and dropped.
      if (s_shk_src.valid && state_q != ST_IDLE) err_d[1] = 1'b1;

      // Tracks the next state so saddr is already stable when ssync fires and reads 0 in IDLE.
      saddr_d = (state_d == ST_IDLE) ? '0
              : base_d + WD_SHK_ADDR'(beat_cnt_d) * BEAT_BYTES;

`ifdef SHK_TO_BRAM_ECHO_EN
      sdata_d = (state_q == ST_WR) ? s_shk_src.mdata : sdata_q;
`else
      sdata_d = '0;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
      if (i_sys_reset) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         beat_cnt_q  <= '0;
         delay_cnt_q <= '0;
         ssync_q     <= 1'b0;
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
         saddr_q     <= '0;
         sdata_q     <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         beat_cnt_q  <= beat_cnt_d;
         delay_cnt_q <= delay_cnt_d;
         ssync_q     <= ssync_d;
         ready_q     <= ready_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         saddr_q     <= saddr_d;
         sdata_q     <= sdata_d;
         err_q       <= err_d;
      end
   end

   assign s_shk_src.ready  = ready_q;
   assign s_shk_src.ssync  = ssync_q;
   assign s_shk_src.saddr  = saddr_q;
   assign s_shk_src.sdata  = sdata_q;

   assign m_bram_dst_clk   = i_sys_clk;
   assign m_bram_dst_addr  = addr_q;
   assign m_bram_dst_din   = din_q;
   assign m_bram_dst_we    = we_q;
   assign m_bram_dst_en    = we_q;
   assign m_bram_dst_rst   = 1'b0;
   assign m_info_rd_last   = ready_q;
   assign m_err_bram_info1 = err_q;

endmodule

// File: tb/tb_shk_to_bram.sv
// Bench for shk_to_bram: a short-burst instance (4 beats, delay 1) and a full-burst instance (256 beats, delay 3),
// each driven by a shake-master model and checked against expected writes, addresses, pacing and error flags.
module tb_shk_to_bram;
   localparam int DW  = 64;
   localparam int AW  = 32;
   localparam int A_N = 4;
   localparam int A_D = 1;
   localparam int B_N = 256;
   localparam int B_D = 3;

   typedef struct {
      int         cyc;
      logic [7:0] addr;
      logic [63:0] data;
   } wr_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   shk_to_bram_if #(.WD_SHK_DATA(DW), .WD_SHK_ADDR(AW)) a_if ();
   shk_to_bram_if #(.WD_SHK_DATA(DW), .WD_SHK_ADDR(AW)) b_if ();

   logic        a_bclk, a_en, a_we, a_brst, a_last;
   logic [7:0]  a_addr;
   logic [63:0] a_din, a_dout;
   logic [3:0]  a_err;
   logic        b_bclk, b_en, b_we, b_brst, b_last;
   logic [7:0]  b_addr;
   logic [63:0] b_din, b_dout;
   logic [3:0]  b_err;

   assign a_dout = '0;
   assign b_dout = '0;

   shk_to_bram #(.NB_BURST(A_N), .NB_MDATA_DELY(A_D)) dut_a (
      .i_sys_clk(clk), .i_sys_reset(rst), .s_shk_src(a_if),
      .m_bram_dst_clk(a_bclk), .m_bram_dst_addr(a_addr), .m_bram_dst_din(a_din),
      .m_bram_dst_dout(a_dout), .m_bram_dst_en(a_en), .m_bram_dst_we(a_we),
      .m_bram_dst_rst(a_brst), .m_info_rd_last(a_last), .m_err_bram_info1(a_err)
   );

   shk_to_bram #(.NB_BURST(B_N), .NB_MDATA_DELY(B_D)) dut_b (
      .i_sys_clk(clk), .i_sys_reset(rst), .s_shk_src(b_if),
      .m_bram_dst_clk(b_bclk), .m_bram_dst_addr(b_addr), .m_bram_dst_din(b_din),
      .m_bram_dst_dout(b_dout), .m_bram_dst_en(b_en), .m_bram_dst_we(b_we),
      .m_bram_dst_rst(b_brst), .m_info_rd_last(b_last), .m_err_bram_info1(b_err)
   );

   // Observed traffic per instance, cleared at the start of each scenario.
   wr_t         a_wr[$], b_wr[$];
   int          a_ss_cyc[$], b_ss_cyc[$];
   logic [31:0] a_ss_addr[$], b_ss_addr[$];
   int          a_rdy[$], b_rdy[$];
   logic [63:0] a_words[A_N];
   logic [63:0] b_words[B_N];
   int          a_misc, b_misc, sdata_nz;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Master model + monitor for A: word k is presented only in the cycle NB_MDATA_DELY after the k-th ssync.
   initial begin
      int due;
      int k;
      wr_t w;
      due = -1; k = 0; a_misc = 0; sdata_nz = 0;
      a_if.mdata = '0;
      forever begin
         @(posedge clk); #1;
         if (a_if.ssync) begin
            a_ss_cyc.push_back(cyc);
            a_ss_addr.push_back(a_if.saddr);
            due = cyc + A_D;
            k   = a_ss_cyc.size() - 1;
         end
         if (cyc == due && k < A_N) a_if.mdata = a_words[k];
         else                       a_if.mdata = {$urandom, $urandom};
         if (a_we) begin
            w.cyc = cyc; w.addr = a_addr; w.data = a_din;
            a_wr.push_back(w);
         end
         if (a_if.ready) a_rdy.push_back(cyc);
         if (a_en !== a_we || a_brst !== 1'b0 || a_last !== a_if.ready || a_bclk !== clk) a_misc++;
         if (a_if.sdata !== '0 || b_if.sdata !== '0) sdata_nz++;
      end
   end

   initial begin
      int due;
      int k;
      wr_t w;
      due = -1; k = 0; b_misc = 0;
      b_if.mdata = '0;
      forever begin
         @(posedge clk); #1;
         if (b_if.ssync) begin
            b_ss_cyc.push_back(cyc);
            b_ss_addr.push_back(b_if.saddr);
            due = cyc + B_D;
            k   = b_ss_cyc.size() - 1;
         end
         if (cyc == due && k < B_N) b_if.mdata = b_words[k];
         else                       b_if.mdata = {$urandom, $urandom};
         if (b_we) begin
            w.cyc = cyc; w.addr = b_addr; w.data = b_din;
            b_wr.push_back(w);
         end
         if (b_if.ready) b_rdy.push_back(cyc);
         if (b_en !== b_we || b_brst !== 1'b0 || b_last !== b_if.ready || b_bclk !== clk) b_misc++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic a_clear();
      a_wr.delete(); a_ss_cyc.delete(); a_ss_addr.delete(); a_rdy.delete();
   endtask

   task automatic b_clear();
      b_wr.delete(); b_ss_cyc.delete(); b_ss_addr.delete(); b_rdy.delete();
   endtask

   task automatic a_req(input logic ms, input logic [31:0] ad, output int vcyc);
      @(negedge clk);
      a_if.valid = 1'b1; a_if.msync = ms; a_if.maddr = ad; vcyc = cyc;
      @(negedge clk);
      a_if.valid = 1'b0; a_if.msync = 1'b0; a_if.maddr = '0;
   endtask

   task automatic b_req(input logic ms, input logic [31:0] ad);
      @(negedge clk);
      b_if.valid = 1'b1; b_if.msync = ms; b_if.maddr = ad;
      @(negedge clk);
      b_if.valid = 1'b0; b_if.msync = 1'b0; b_if.maddr = '0;
   endtask

   task automatic a_wait_ready(input string tag, input int budget);
      int i;
      i = 0;
      while (a_rdy.size() < 1 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check({tag, "_ready_seen"}, 64'(a_rdy.size() >= 1), 64'd1);
      tick(4);
   endtask

   // Expected burst on A: beat k writes words[k] at BRAM address k, saddr = base + 8k, ssync every 2+D cycles.
   task automatic a_check_burst(input string tag, input logic [31:0] base);
      logic [31:0] exp_saddr;
      check({tag, "_nwr"}, 64'(a_wr.size()), 64'(A_N));
      check({tag, "_nss"}, 64'(a_ss_cyc.size()), 64'(A_N));
      check({tag, "_nrdy"}, 64'(a_rdy.size()), 64'd1);
      for (int k = 0; k < A_N && k < a_wr.size(); k++) begin
         check($sformatf("%s_addr%0d", tag, k), 64'(a_wr[k].addr), 64'(k));
         check($sformatf("%s_data%0d", tag, k), a_wr[k].data, a_words[k]);
      end
      for (int k = 0; k < A_N && k < a_ss_cyc.size(); k++) begin
         exp_saddr = base + 32'(k * (DW / 8));
         check($sformatf("%s_saddr%0d", tag, k), 64'(a_ss_addr[k]), 64'(exp_saddr));
         if (k > 0)
            check($sformatf("%s_period%0d", tag, k), 64'(a_ss_cyc[k] - a_ss_cyc[k-1]), 64'(2 + A_D));
      end
   endtask

   initial begin
      int vc;
      int i;
      int bad_addr, bad_data, bad_period, bad_saddr;
      logic [31:0] base;
      n_checks = 0; n_errors = 0;
      a_if.valid = 1'b0; a_if.msync = 1'b0; a_if.maddr = '0;
      b_if.valid = 1'b0; b_if.msync = 1'b0; b_if.maddr = '0;
      rst = 1'b1;
      tick(3);

      check("rst_a_ssync", 64'(a_if.ssync), 64'd0);
      check("rst_a_ready", 64'(a_if.ready), 64'd0);
      check("rst_a_we",    64'(a_we), 64'd0);
      check("rst_a_saddr", 64'(a_if.saddr), 64'd0);
      check("rst_a_err",   64'(a_err), 64'd0);
      check("rst_b_ssync", 64'(b_if.ssync), 64'd0);
      check("rst_b_err",   64'(b_err), 64'd0);

      @(negedge clk); rst = 1'b0;
      tick(2);

      // Nominal 4-beat write burst with 0xA0+k data.
      for (int k = 0; k < A_N; k++) a_words[k] = 64'hA0 + 64'(k);
      a_clear();
      a_req(1'b1, 32'h0200_0000, vc);
      a_wait_ready("t1", 60);
      a_check_burst("t1", 32'h0200_0000);
      check("t1_err", 64'(a_err), 64'd0);
`ifdef SHK_TO_BRAM_ECHO_EN
      check("t1_sdata", a_if.sdata, 64'hA3);
`else
      check("t1_sdata", a_if.sdata, 64'h0);
`endif

      // Read request: unsupported, no writes, ready two cycles after valid.
      a_clear();
      a_req(1'b0, 32'h0400_0000, vc);
      a_wait_ready("t2", 20);
      check("t2_nwr",  64'(a_wr.size()), 64'd0);
      check("t2_nrdy", 64'(a_rdy.size()), 64'd1);
      if (a_rdy.size() > 0) check("t2_latency", 64'(a_rdy[0] - vc), 64'd2);
      check("t2_err", 64'(a_err), 64'h1);

      // Second request during beat 1 is ignored and flagged.
      for (int k = 0; k < A_N; k++) a_words[k] = {$urandom, $urandom};
      base = $urandom & 32'hFFFF_FFF8;
      a_clear();
      a_req(1'b1, base, vc);
      i = 0;
      while (a_ss_cyc.size() < 2 && i < 40) begin @(negedge clk); i++; end
      check("t3_beat1_seen", 64'(a_ss_cyc.size() >= 2), 64'd1);
      a_req(1'b1, 32'hDEAD_BEE0, vc);
      a_wait_ready("t3", 60);
      a_check_burst("t3", base);
      check("t3_err", 64'(a_err), 64'h3);

      // Reset after the 2nd write aborts the burst with no ready.
      for (int k = 0; k < A_N; k++) a_words[k] = {$urandom, $urandom};
      a_clear();
      a_req(1'b1, 32'h0300_0040, vc);
      i = 0;
      while (a_wr.size() < 2 && i < 40) begin @(negedge clk); i++; end
      check("t4_two_writes", 64'(a_wr.size()), 64'd2);
      rst = 1'b1;
      #1;
      check("t4_rst_ssync", 64'(a_if.ssync), 64'd0);
      check("t4_rst_ready", 64'(a_if.ready), 64'd0);
      check("t4_rst_last",  64'(a_last), 64'd0);
      check("t4_rst_we",    64'({a_we, a_en}), 64'd0);
      check("t4_rst_addr",  64'(a_addr), 64'd0);
      check("t4_rst_din",   a_din, 64'd0);
      check("t4_rst_saddr", 64'(a_if.saddr), 64'd0);
      check("t4_rst_sdata", a_if.sdata, 64'd0);
      check("t4_rst_err",   64'(a_err), 64'd0);
      tick(4);
      @(negedge clk); rst = 1'b0;
      tick(2);
      check("t4_no_ready", 64'(a_rdy.size()), 64'd0);
      check("t4_no_more_wr", 64'(a_wr.size()), 64'd2);
      for (int k = 0; k < A_N; k++) a_words[k] = {$urandom, $urandom};
      base = $urandom & 32'hFFFF_FFF8;
      a_clear();
      a_req(1'b1, base, vc);
      a_wait_ready("t4b", 60);
      a_check_burst("t4b", base);
      check("t4b_err", 64'(a_err), 64'd0);

      // Full 256-beat burst, delay 3, misaligned base.
      for (int k = 0; k < B_N; k++) b_words[k] = {$urandom, $urandom};
      base = 32'h1000_0004;
      b_clear();
      b_req(1'b1, base);
      i = 0;
      while (b_rdy.size() < 1 && i < 2000) begin @(negedge clk); i++; end
      check("t5_ready_seen", 64'(b_rdy.size() >= 1), 64'd1);
      tick(4);
      check("t5_nwr",  64'(b_wr.size()), 64'(B_N));
      check("t5_nrdy", 64'(b_rdy.size()), 64'd1);
      if (b_wr.size() > 0) check("t5_last_addr", 64'(b_wr[b_wr.size()-1].addr), 64'd255);
      bad_addr = 0; bad_data = 0; bad_period = 0; bad_saddr = 0;
      for (int k = 0; k < b_wr.size() && k < B_N; k++) begin
         if (b_wr[k].addr !== 8'(k))       bad_addr++;
         if (b_wr[k].data !== b_words[k])  bad_data++;
      end
      for (int k = 0; k < b_ss_cyc.size(); k++) begin
         if (b_ss_addr[k] !== base + 32'(k * (DW / 8))) bad_saddr++;
         if (k > 0 && b_ss_cyc[k] - b_ss_cyc[k-1] != 2 + B_D) bad_period++;
      end
      check("t5_nss",        64'(b_ss_cyc.size()), 64'(B_N));
      check("t5_bad_addr",   64'(bad_addr), 64'd0);
      check("t5_bad_data",   64'(bad_data), 64'd0);
      check("t5_bad_saddr",  64'(bad_saddr), 64'd0);
      check("t5_bad_period", 64'(bad_period), 64'd0);
      check("t5_err",        64'(b_err), 64'h4);

      // Beat counter wrapped: the next burst starts again at BRAM address 0.
      b_clear();
      b_req(1'b1, 32'h2000_0000);
      i = 0;
      while (b_wr.size() < 1 && i < 40) begin @(negedge clk); i++; end
      check("t5b_first_wr_seen", 64'(b_wr.size() >= 1), 64'd1);
      if (b_wr.size() > 0) check("t5b_first_addr", 64'(b_wr[0].addr), 64'd0);
      if (b_ss_addr.size() > 0) check("t5b_first_saddr", 64'(b_ss_addr[0]), 64'h2000_0000);

      check("misc_a_en_last_rst", 64'(a_misc), 64'd0);
      check("misc_b_en_last_rst", 64'(b_misc), 64'd0);
`ifndef SHK_TO_BRAM_ECHO_EN
      check("sdata_always_zero", 64'(sdata_nz), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
